// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle DIVU controller and HI/LO owner for the EX stage
module div_sequencer #(
  parameter int WIDTH = 32,
  parameter int STEPS = WIDTH
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_ex_valid,
  input  logic [5:0]       i_funct,
  input  logic [WIDTH-1:0] i_rs_val,
  input  logic [WIDTH-1:0] i_rt_val,
  output logic             o_stall,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_hi_out,
  output logic [WIDTH-1:0] o_lo_out,
  output logic [WIDTH-1:0] o_mf_data,
  output logic             o_div_by_zero
);
  localparam logic [5:0] F_DIVU = 6'b011011;
  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MTHI = 6'b010001;
  localparam logic [5:0] F_MFLO = 6'b010010;
  localparam logic [5:0] F_MTLO = 6'b010011;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo, r_dvs, r_hi, r_lo;
  logic [5:0]       r_cnt;
  logic             r_dbz;
  logic             w_hilo_op, w_idle, w_last, w_ge;
  logic [WIDTH:0]   w_t, w_sub;
  assign w_hilo_op = i_ex_valid & (i_funct == F_DIVU | i_funct == F_MFHI | i_funct == F_MFLO |
                                   i_funct == F_MTHI | i_funct == F_MTLO);
  assign w_idle    = r_state == IDLE;
  assign w_last    = r_cnt == 6'(STEPS - 1);
  assign w_t       = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
  assign w_ge      = w_t >= {1'b0, r_dvs};
  assign w_sub     = w_t - {1'b0, r_dvs};
  assign o_stall   = w_hilo_op & ~w_idle & ~i_reset;
  assign o_busy    = ~w_idle;
  assign o_hi_out  = r_hi;
  assign o_lo_out  = r_lo;
  assign o_mf_data = i_funct == F_MFHI ? r_hi : r_lo;
  assign o_div_by_zero = r_dbz;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = i_ex_valid & i_funct == F_DIVU ? RUN : IDLE;
      RUN:     w_next = w_last ? DONE : RUN;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk)
    r_state <= i_reset ? IDLE : w_next;
  // Moves only write in IDLE; a stalled move is re-presented by the pipeline
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rem <= '0;
      r_quo <= '0;
      r_dvs <= '0;
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_dbz <= 1'b0;
    end else if (w_idle) begin
      if (i_ex_valid & i_funct == F_DIVU) begin
        r_rem <= '0;
        r_quo <= i_rs_val;
        r_dvs <= i_rt_val;
        r_cnt <= '0;
        r_dbz <= i_rt_val == '0;
      end
      if (i_ex_valid & i_funct == F_MTHI) r_hi <= i_rs_val;
      if (i_ex_valid & i_funct == F_MTLO) r_lo <= i_rs_val;
    end else if (r_state == RUN) begin
      r_rem <= w_ge ? w_sub : w_t;
      r_quo <= {r_quo[WIDTH-2:0], w_ge};
      r_cnt <= r_cnt + 6'd1;
    end else begin
      r_hi <= r_rem[WIDTH-1:0];
      r_lo <= r_quo;
    end
  end
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed vectors for div_sequencer with hand-computed results
module tb_div_sequencer;
  localparam logic [5:0] F_DIVU = 6'b011011;
  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MTHI = 6'b010001;
  localparam logic [5:0] F_MFLO = 6'b010010;
  localparam logic [5:0] F_MTLO = 6'b010011;
  logic        clk = 1'b0, reset = 1'b1, ex_valid = 1'b0;
  logic [5:0]  funct = '0;
  logic [31:0] rs_val = '0, rt_val = '0;
  logic        stall, busy, div_by_zero;
  logic [31:0] hi_out, lo_out, mf_data;
  int          n_tests = 0, n_fail = 0, n;
  div_sequencer dut (
    .i_clk(clk), .i_reset(reset), .i_ex_valid(ex_valid), .i_funct(funct),
    .i_rs_val(rs_val), .i_rt_val(rt_val), .o_stall(stall), .o_busy(busy),
    .o_hi_out(hi_out), .o_lo_out(lo_out), .o_mf_data(mf_data), .o_div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    ex_valid = 1'b1;
    funct = f;
    rs_val = a;
    rt_val = b;
    #1;
  endtask
  task automatic count_busy(output int c);
    c = 0;
    while (busy && c < 100) begin
      c++;
      tick();
    end
  endtask
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, output int c);
    issue(F_DIVU, a, b);
    check("divu_no_stall", {31'b0, stall}, 32'd0);
    tick();
    ex_valid = 1'b0;
    #1;
    count_busy(c);
  endtask
  initial begin
    tick();
    tick();
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_hi", hi_out, 32'd0);
    check("rst_lo", lo_out, 32'd0);
    check("rst_mf", mf_data, 32'd0);
    check("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    reset = 1'b0;
    #1;
    do_div(32'd100, 32'd7, n);
    check("basic_busy_cycles", n, 33);
    check("basic_hi", hi_out, 32'd2);
    check("basic_lo", lo_out, 32'd14);
    check("basic_dbz", {31'b0, div_by_zero}, 32'd0);
    issue(F_MTHI, 32'hA5A5A5A5, 32'd0);
    check("mthi_stall", {31'b0, stall}, 32'd0);
    tick();
    issue(F_MFHI, 32'd0, 32'd0);
    check("mfhi_data", mf_data, 32'hA5A5A5A5);
    check("mfhi_stall", {31'b0, stall}, 32'd0);
    issue(F_MFLO, 32'd0, 32'd0);
    check("mflo_data", mf_data, 32'd14);
    // MFHI held behind a running divide
    issue(F_DIVU, 32'd100, 32'd7);
    tick();
    issue(F_MFHI, 32'd0, 32'd0);
    n = 0;
    while (stall && n < 100) begin
      n++;
      if (n == 10) check("hazard_hi_stable", hi_out, 32'hA5A5A5A5);
      tick();
    end
    check("hazard_stall_cycles", n, 33);
    check("hazard_mf", mf_data, 32'd2);
    check("hazard_stall_off", {31'b0, stall}, 32'd0);
    ex_valid = 1'b0;
    do_div(32'h12345678, 32'd0, n);
    check("dbz_busy_cycles", n, 33);
    check("dbz_hi", hi_out, 32'h12345678);
    check("dbz_lo", lo_out, 32'hFFFFFFFF);
    check("dbz_flag", {31'b0, div_by_zero}, 32'd1);
    do_div(32'd9, 32'd3, n);
    check("d9_3_hi", hi_out, 32'd0);
    check("d9_3_lo", lo_out, 32'd3);
    check("d9_3_dbz", {31'b0, div_by_zero}, 32'd0);
    do_div(32'hFFFFFFFF, 32'd1, n);
    check("max_1_hi", hi_out, 32'd0);
    check("max_1_lo", lo_out, 32'hFFFFFFFF);
    do_div(32'd5, 32'hFFFFFFFF, n);
    check("5_max_hi", hi_out, 32'd5);
    check("5_max_lo", lo_out, 32'd0);
    // reset pulsed mid-RUN discards the division
    issue(F_DIVU, 32'd100, 32'd7);
    tick();
    ex_valid = 1'b0;
    repeat (9) tick();
    check("mid_busy_pre", {31'b0, busy}, 32'd1);
    issue(F_MFHI, 32'd0, 32'd0);
    reset = 1'b1;
    #1;
    check("rst_forces_stall0", {31'b0, stall}, 32'd0);
    tick();
    reset = 1'b0;
    ex_valid = 1'b0;
    #1;
    check("mid_busy", {31'b0, busy}, 32'd0);
    check("mid_hi", hi_out, 32'd0);
    check("mid_lo", lo_out, 32'd0);
    repeat (30) tick();
    check("mid_no_write_hi", hi_out, 32'd0);
    check("mid_no_write_lo", lo_out, 32'd0);
    check("mid_no_busy", {31'b0, busy}, 32'd0);
    // MTLO held while busy, then applied after DONE
    issue(F_DIVU, 32'd100, 32'd7);
    tick();
    issue(F_MTLO, 32'h55, 32'd0);
    n = 0;
    while (stall && n < 100) begin
      n++;
      if (n == 20) check("mtlo_lo_held", lo_out, 32'd0);
      tick();
    end
    check("mtlo_stall_cycles", n, 33);
    check("mtlo_lo_done", lo_out, 32'd14);
    tick();
    ex_valid = 1'b0;
    #1;
    check("mtlo_applied", lo_out, 32'h55);
    // DIVU presented during DONE is accepted once IDLE
    issue(F_DIVU, 32'd100, 32'd7);
    tick();
    ex_valid = 1'b0;
    repeat (32) tick();
    issue(F_DIVU, 32'd9, 32'd3);
    check("done_stall", {31'b0, stall}, 32'd1);
    tick();
    check("idle_stall", {31'b0, stall}, 32'd0);
    check("done_hi", hi_out, 32'd2);
    check("done_lo", lo_out, 32'd14);
    tick();
    ex_valid = 1'b0;
    #1;
    check("b2b_busy", {31'b0, busy}, 32'd1);
    count_busy(n);
    check("b2b_busy_cycles", n, 33);
    check("b2b_hi", hi_out, 32'd0);
    check("b2b_lo", lo_out, 32'd3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
